// File: rtl/branch_predictor.sv
// IF-stage next-PC predictor: direct-mapped BTB plus 2-bit saturating counters.
// Define GSHARE_EN to XOR table indices with a non-speculative global history register.
module branch_predictor #(
    parameter int INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           current_pc,
    output logic [31:0]           next_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_ghr,
    input  logic                  update_valid,
    input  logic                  update_is_branch,
    input  logic [31:0]           update_pc,
    input  logic                  update_taken,
    input  logic [31:0]           update_target,
    input  logic [INDEX_BITS-1:0] update_ghr
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 30 - INDEX_BITS;

    logic [ENTRIES-1:0]             valid;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][31:0]       target_q;
    logic [ENTRIES-1:0][1:0]        ctr_q;
    logic [INDEX_BITS-1:0]          ghr, li, ui;
    logic                           hit;

`ifdef GSHARE_EN
    // History only moves on resolved conditional branches, never speculatively.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ghr <= '0;
        else if (update_valid && update_is_branch)
            ghr <= {ghr[INDEX_BITS-2:0], update_taken};
    end

    assign li = current_pc[INDEX_BITS+1:2] ^ ghr;
    assign ui = update_pc[INDEX_BITS+1:2] ^ update_ghr;

    logic unused_bits;
    assign unused_bits = ^update_pc[1:0];
`else
    assign ghr = '0;
    assign li  = current_pc[INDEX_BITS+1:2];
    assign ui  = update_pc[INDEX_BITS+1:2];

    logic unused_bits;
    assign unused_bits = ^{update_ghr, update_pc[1:0]};
`endif

    // Lookup reads pre-update contents; valid clears asynchronously so reset forces pc+4.
    assign hit        = valid[li] && (tag_q[li] == current_pc[31:INDEX_BITS+2]);
    assign pred_taken = hit && ctr_q[li][1];
    assign next_pc    = pred_taken ? target_q[li] : current_pc + 32'd4;
    assign pred_ghr   = ghr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            ctr_q <= {ENTRIES{2'b01}};
        end else if (update_valid) begin
            if (update_taken)
                valid[ui] <= 1'b1;
            if (!update_is_branch)
                ctr_q[ui] <= 2'b11;
            else if (update_taken && ctr_q[ui] != 2'b11)
                ctr_q[ui] <= ctr_q[ui] + 2'd1;
            else if (!update_taken && ctr_q[ui] != 2'b00)
                ctr_q[ui] <= ctr_q[ui] - 2'd1;
        end
    end

    // Tags and targets need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (update_valid && update_taken) begin
            tag_q[ui]    <= update_pc[31:INDEX_BITS+2];
            target_q[ui] <= update_target;
        end
    end
endmodule
